// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// A {bcd, bin} register is shifted right W times. After each shift, every BCD
// digit that is 8 or more has 3 subtracted, so the binary field fills with the
// result from the top down. One conversion runs per start/done handshake.
// Requests with a digit above 9 finish at once with err set, and bin_out is left unchanged.
module bcd_to_bin_seq #(
  parameter int NDIG = 2,
  parameter int W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [W-1:0]      bin_out
);

  localparam int SRW = 4*NDIG + W;
  localparam int CW  = $clog2(W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [W-1:0]     bin_q, bin_d;

  logic             digits_ok;
  logic [SRW-1:0]   shifted;
  logic [SRW-1:0]   corrected;

  // Flag whether every input digit is a legal decimal digit (0..9)
  always_comb begin
    digits_ok = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        digits_ok = 1'b0;
      end
    end
  end

  // One reverse double-dabble step: shift right, then subtract 3 from digits >= 8
  always_comb begin
    shifted   = sr_q >> 1;
    corrected = shifted;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (shifted[W + 4*i + 3]) begin
        corrected[W + 4*i +: 4] = shifted[W + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Next-state and output logic for the IDLE/SHIFT controller
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (digits_ok) begin
            sr_d    = {bcd_in, {W{1'b0}}};
            cnt_d   = CW'(W);
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = SHIFT;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        sr_d  = corrected;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bin_d   = corrected[W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a cycle-level behavioural model (decimal arithmetic
// plus a remaining-cycles countdown) is checked against a 2-digit instance on
// every cycle. Directed vectors pin literal results on 2- and 3-digit instances.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bcd;
  logic        busy, done, err;
  logic [6:0]  bin_out;

  logic        start3;
  logic [11:0] bcd3;
  logic        busy3, done3, err3;
  logic [9:0]  bin3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.NDIG(2), .W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd),
    .busy(busy), .done(done), .err(err), .bin_out(bin_out)
  );

  bcd_to_bin_seq #(.NDIG(3), .W(10)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .err(err3), .bin_out(bin3)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of a 2-digit BCD word, or -1 if any digit is above 9
  function automatic int dec_value(input logic [7:0] b);
    int hi, lo;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9 || lo > 9) return -1;
    return hi * 10 + lo;
  endfunction

  // Behavioural model of the 2-digit instance
  int m_rem  = 0;
  int m_pend = 0;
  int m_bin  = 0;
  bit m_busy = 0, m_done = 0, m_err = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_pend = 0; m_bin = 0;
      m_busy = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_done = 1;
          m_bin  = m_pend;
        end
      end else if (start) begin
        if (dec_value(bcd) >= 0) begin
          m_pend = dec_value(bcd);
          m_rem  = 7;
          m_busy = 1;
          m_err  = 0;
        end else begin
          m_done = 1;
          m_err  = 1;
        end
      end
    end
  end

  // Compare the DUT against the model shortly after every rising edge
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      check("model busy", busy, m_busy);
      check("model done", done, m_done);
      check("model err", err, m_err);
      check("model bin_out", bin_out, m_bin);
    end
  end

  // Issue one request at a falling edge and wait (bounded) for done.
  // Returns at the falling edge where done is visible.
  task automatic conv(input string nm, input logic [7:0] b, input int exp_lat,
                      input int exp_bin, input bit exp_err);
    int lat;
    bcd = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " done"}, done, 1);
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " bin_out"}, bin_out, exp_bin);
    check({nm, " err"}, err, exp_err);
  endtask

  task automatic conv3(input string nm, input logic [11:0] b, input int exp_lat,
                       input int exp_bin, input bit exp_err);
    int lat;
    bcd3 = b;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " done"}, done3, 1);
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " bin_out"}, bin3, exp_bin);
    check({nm, " err"}, err3, exp_err);
  endtask

  initial begin
    int lat;
    logic [7:0] v8;
    rst = 1'b1;
    start = 1'b0;
    bcd = '0;
    start3 = 1'b0;
    bcd3 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset bin_out", bin_out, 0);
    rst = 1'b0;
    @(negedge clk);

    conv("h42", 8'h42, 7, 42, 0);
    conv("h99", 8'h99, 7, 99, 0);
    conv("h00", 8'h00, 7, 0, 0);
    conv("h42 again", 8'h42, 7, 42, 0);
    conv("h3A invalid", 8'h3A, 0, 42, 1);
    conv("h15 clears err", 8'h15, 7, 15, 0);

    // start pulses during a busy conversion are ignored; bcd_in changes are too
    bcd = 8'h07;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      start = (lat == 1 || lat == 3);
      if (start) bcd = 8'h55;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("ignore done", done, 1);
    check("ignore latency", lat, 7);
    check("ignore bin_out", bin_out, 7);
    @(negedge clk);
    check("ignore single done", done, 0);
    repeat (8) @(negedge clk);
    check("ignore no second done", bin_out, 7);

    // Reset in the middle of a conversion
    bcd = 8'h88;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort err", err, 0);
    check("abort bin_out", bin_out, 0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    conv("h88 after abort", 8'h88, 7, 88, 0);

    // Exhaustive, each new start raised in the done cycle of the previous one
    for (int v = 0; v < 100; v++) begin
      v8 = {4'(v / 10), 4'(v % 10)};
      conv("sweep", v8, 7, v, 0);
    end
    @(negedge clk);

    conv3("h999", 12'h999, 10, 999, 0);
    conv3("h123", 12'h123, 10, 123, 0);
    conv3("h9A0 invalid", 12'h9A0, 0, 123, 1);
    conv3("h000", 12'h000, 10, 0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
